// File: rtl/stopwatch_pkg.sv
// Shared stopwatch display definitions: slot states and active-low 7-segment patterns.
// Patterns are ordered {g,f,e,d,c,b,a}.
package stopwatch_pkg;

    typedef enum logic [0:0] {
        S_BLANK = 1'b0,
        S_DRIVE = 1'b1
    } slot_state_t;

    localparam logic [6:0] SEG_OFF  = 7'b1111111;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;

endpackage

// File: rtl/seg_scan_scheduler_if.sv
// Display-side bundle of the scan scheduler: BCD time and controls in,
// anode/segment/decimal-point drives and the frame marker out.
interface seg_scan_scheduler_if #(
    parameter int DIGITS = 6
);
    logic [4*DIGITS-1:0] time_bcd;
    logic                disp_update;
    logic                blink_en;
    logic [DIGITS-1:0]   an_n;
    logic [6:0]          seg_n;
    logic                dp_n;
    logic                frame_start;

    modport master (
        output time_bcd, disp_update, blink_en,
        input  an_n, seg_n, dp_n, frame_start
    );

    modport slave (
        input  time_bcd, disp_update, blink_en,
        output an_n, seg_n, dp_n, frame_start
    );
endinterface

// File: rtl/bcd_to_seg.sv
// Combinational BCD to active-low 7-segment decoder; codes 10..15 show a dash.
module bcd_to_seg
    import stopwatch_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg_n
);

    always_comb begin
        seg_n = SEG_DASH;
        case (bcd)
            4'd0: seg_n = SEG_0;
            4'd1: seg_n = SEG_1;
            4'd2: seg_n = SEG_2;
            4'd3: seg_n = SEG_3;
            4'd4: seg_n = SEG_4;
            4'd5: seg_n = SEG_5;
            4'd6: seg_n = SEG_6;
            4'd7: seg_n = SEG_7;
            4'd8: seg_n = SEG_8;
            4'd9: seg_n = SEG_9;
            default: seg_n = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg_scan_scheduler.sv
// Multiplexed 7-segment scan scheduler with frame-aligned snapshot and blink.
// Optional build macro SEG_LEADING_ZERO_BLANK_EN blanks leading zero digits above digit 2.
module seg_scan_scheduler
    import stopwatch_pkg::*;
#(
    parameter int CLK_DIV      = 1000,
    parameter int BLANK_CYCLES = 100,
    parameter int DIGITS       = 6,
    parameter int BLINK_FRAMES = 50
) (
    input  logic                 clk,
    input  logic                 n_reset,
    seg_scan_scheduler_if.slave  bus
);

    localparam int PC_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int DIG_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int FC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [PC_W-1:0]  PC_LAST  = PC_W'(CLK_DIV - 1);
    localparam logic [PC_W-1:0]  PC_BLANK = PC_W'(BLANK_CYCLES);
    localparam logic [DIG_W-1:0] DIG_LAST = DIG_W'(DIGITS - 1);
    localparam logic [DIG_W-1:0] DIG_DP_A = DIG_W'(2);
    localparam logic [DIG_W-1:0] DIG_DP_B = DIG_W'(4);
    localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(BLINK_FRAMES - 1);

    logic [PC_W-1:0]     pc;
    logic [DIG_W-1:0]    dig;
    logic [FC_W-1:0]     fc;
    logic                ph;
    logic [4*DIGITS-1:0] snap;
    logic                blk;
    logic                primed;

    slot_state_t         state;
    logic                slot_end;
    logic                frame_end;
    logic [3:0]          nib;
    logic [6:0]          seg_dec;
    logic [DIGITS-1:0]   suppress;
    logic                dark;

    logic [DIGITS-1:0]   an_n_p1;
    logic [6:0]          seg_n_p1;
    logic                dp_n_p1;
    logic                frame_start_p1;

    assign state     = (pc < PC_BLANK) ? S_BLANK : S_DRIVE;
    assign slot_end  = (pc == PC_LAST);
    assign frame_end = slot_end && (dig == DIG_LAST);
    assign nib       = snap[4*dig +: 4];

    bcd_to_seg u_dec (
        .bcd   (nib),
        .seg_n (seg_dec)
    );

`ifdef SEG_LEADING_ZERO_BLANK_EN
    // Zero run scanned from the top digit; the three low digits always show.
    always_comb begin
        logic run;
        run      = 1'b1;
        suppress = '0;
        for (int i = DIGITS - 1; i >= 3; i--) begin
            run         = run && (snap[4*i +: 4] == 4'd0);
            suppress[i] = run;
        end
    end
`else
    assign suppress = '0;
`endif

    assign dark = (state == S_BLANK) || (blk && ph) || suppress[dig];

    // Stage p0: scan counters and the frame-boundary snapshot
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            pc     <= '0;
            dig    <= '0;
            fc     <= '0;
            ph     <= 1'b0;
            snap   <= '0;
            blk    <= 1'b0;
            primed <= 1'b0;
        end else begin
            if (slot_end) begin
                pc  <= '0;
                dig <= (dig == DIG_LAST) ? '0 : dig + 1'b1;
            end else begin
                pc <= pc + 1'b1;
            end
            if (frame_end) begin
                primed <= 1'b1;
                blk    <= bus.blink_en;
                if (bus.disp_update) begin
                    snap <= bus.time_bcd;
                end
                if (fc == FC_LAST) begin
                    fc <= '0;
                    ph <= ~ph;
                end else begin
                    fc <= fc + 1'b1;
                end
            end
        end
    end

    // Stage p1: registered display drive, one cycle behind the counters
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            an_n_p1        <= '1;
            seg_n_p1       <= SEG_OFF;
            dp_n_p1        <= 1'b1;
            frame_start_p1 <= 1'b0;
        end else begin
            frame_start_p1 <= primed && (pc == '0) && (dig == '0);
            if (dark) begin
                an_n_p1  <= '1;
                seg_n_p1 <= SEG_OFF;
                dp_n_p1  <= 1'b1;
            end else begin
                an_n_p1  <= ~(DIGITS'(1) << dig);
                seg_n_p1 <= seg_dec;
                dp_n_p1  <= !((dig == DIG_DP_A) || (dig == DIG_DP_B));
            end
        end
    end

    assign bus.an_n        = an_n_p1;
    assign bus.seg_n       = seg_n_p1;
    assign bus.dp_n        = dp_n_p1;
    assign bus.frame_start = frame_start_p1;

endmodule

// File: tb/tb_seg_scan_scheduler.sv
// Directed bench for seg_scan_scheduler: scan order, freeze, mid-frame change,
// blink, invalid codes, leading-zero option and asynchronous reset.
module tb_seg_scan_scheduler;

    localparam int CLK_DIV      = 8;
    localparam int BLANK_CYCLES = 2;
    localparam int DIGITS       = 6;
    localparam int BLINK_FRAMES = 2;
    localparam int FRAME        = CLK_DIV * DIGITS;

`ifdef SEG_LEADING_ZERO_BLANK_EN
    localparam bit LZ_EN = 1'b1;
`else
    localparam bit LZ_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic n_reset;
    int   n_checks = 0;
    int   n_errors = 0;

    seg_scan_scheduler_if #(.DIGITS(DIGITS)) bus ();

    seg_scan_scheduler #(
        .CLK_DIV      (CLK_DIV),
        .BLANK_CYCLES (BLANK_CYCLES),
        .DIGITS       (DIGITS),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) dut (
        .clk     (clk),
        .n_reset (n_reset),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Hand-written active-low {g,f,e,d,c,b,a} patterns.
    function automatic logic [6:0] exp_seg(input logic [3:0] d);
        case (d)
            4'd0: return 7'h40;
            4'd1: return 7'h79;
            4'd2: return 7'h24;
            4'd3: return 7'h30;
            4'd4: return 7'h19;
            4'd5: return 7'h12;
            4'd6: return 7'h02;
            4'd7: return 7'h78;
            4'd8: return 7'h00;
            4'd9: return 7'h10;
            default: return 7'h3F;
        endcase
    endfunction

    function automatic bit lz_blank(input logic [23:0] s, input int d);
        if (!LZ_EN || d < 3) return 1'b0;
        for (int j = DIGITS - 1; j >= d; j--) begin
            if (s[4*j +: 4] != 4'd0) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Checks ncyc output cycles of one frame showing snapshot s; optionally
    // changes the inputs right after sampling cycle chg_at.
    task automatic run_frame(input string name, input logic [23:0] s, input bit blink_dark,
                             input bit fs_on, input int ncyc, input int chg_at,
                             input logic [23:0] chg_bcd, input logic chg_upd, input logic chg_blink);
        for (int i = 0; i < ncyc; i++) begin
            int         p;
            int         d;
            bit         dark;
            logic [5:0] an_e;
            logic [6:0] seg_e;
            logic       dp_e;
            @(posedge clk);
            #1;
            p     = i % CLK_DIV;
            d     = i / CLK_DIV;
            dark  = (p < BLANK_CYCLES) || blink_dark || lz_blank(s, d);
            an_e  = dark ? 6'h3F : ~(6'd1 << d);
            seg_e = dark ? 7'h7F : exp_seg(s[4*d +: 4]);
            dp_e  = dark ? 1'b1 : !((d == 2) || (d == 4));
            check_val($sformatf("%s an_n c%0d", name, i), 32'(bus.an_n), 32'(an_e));
            check_val($sformatf("%s seg_n c%0d", name, i), 32'(bus.seg_n), 32'(seg_e));
            check_val($sformatf("%s dp_n c%0d", name, i), 32'(bus.dp_n), 32'(dp_e));
            check_val($sformatf("%s frame_start c%0d", name, i), 32'(bus.frame_start),
                      32'(fs_on && (i == 0)));
            if (i == chg_at) begin
                bus.time_bcd    = chg_bcd;
                bus.disp_update = chg_upd;
                bus.blink_en    = chg_blink;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.time_bcd    = 24'h123456;
        bus.disp_update = 1'b1;
        bus.blink_en    = 1'b0;
        n_reset         = 1'b1;
        #3 n_reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_val("reset an_n", 32'(bus.an_n), 32'h3F);
        check_val("reset seg_n", 32'(bus.seg_n), 32'h7F);
        check_val("reset dp_n", 32'(bus.dp_n), 32'h1);
        check_val("reset frame_start", 32'(bus.frame_start), 32'h0);
        @(negedge clk);
        n_reset = 1'b1;

        // Frame 0 after reset shows zeros and has no frame_start pulse.
        run_frame("F0", 24'h000000, 1'b0, 1'b0, FRAME, -1, 24'h0, 1'b1, 1'b0);
        // Freeze: disp_update dropped and new value presented mid-frame.
        run_frame("F1", 24'h123456, 1'b0, 1'b1, FRAME, 10, 24'h999999, 1'b0, 1'b0);
        run_frame("F2", 24'h123456, 1'b0, 1'b1, FRAME, 20, 24'h999999, 1'b1, 1'b0);
        // Unfrozen; change during digit 3 must not tear this frame.
        run_frame("F3", 24'h999999, 1'b0, 1'b1, FRAME, 27, 24'h654321, 1'b1, 1'b0);
        run_frame("F4", 24'h654321, 1'b0, 1'b1, FRAME, 5, 24'h654321, 1'b1, 1'b1);
        // Blink phase: frames 6,7 dark, 5,8,9 visible.
        run_frame("F5", 24'h654321, 1'b0, 1'b1, FRAME, -1, 24'h0, 1'b1, 1'b1);
        run_frame("F6", 24'h654321, 1'b1, 1'b1, FRAME, -1, 24'h0, 1'b1, 1'b1);
        run_frame("F7", 24'h654321, 1'b1, 1'b1, FRAME, -1, 24'h0, 1'b1, 1'b1);
        run_frame("F8", 24'h654321, 1'b0, 1'b1, FRAME, -1, 24'h0, 1'b1, 1'b1);
        run_frame("F9", 24'h654321, 1'b0, 1'b1, FRAME, 5, 24'h654321, 1'b1, 1'b0);
        // Phase would be dark here, but blink is cleared.
        run_frame("F10", 24'h654321, 1'b0, 1'b1, FRAME, 5, 24'h00A012, 1'b1, 1'b0);
        run_frame("F11", 24'h00A012, 1'b0, 1'b1, FRAME, -1, 24'h0, 1'b1, 1'b0);
        // Stop in the drive phase of digit 3, then reset asynchronously.
        run_frame("F12", 24'h00A012, 1'b0, 1'b1, 29, -1, 24'h0, 1'b1, 1'b0);
        #2 n_reset = 1'b0;
        #1;
        check_val("rst_mid an_n", 32'(bus.an_n), 32'h3F);
        check_val("rst_mid seg_n", 32'(bus.seg_n), 32'h7F);
        check_val("rst_mid dp_n", 32'(bus.dp_n), 32'h1);
        check_val("rst_mid frame_start", 32'(bus.frame_start), 32'h0);
        @(negedge clk);
        @(negedge clk);
        n_reset = 1'b1;
        run_frame("R0", 24'h000000, 1'b0, 1'b0, FRAME, -1, 24'h0, 1'b1, 1'b0);
        run_frame("R1", 24'h00A012, 1'b0, 1'b1, FRAME, -1, 24'h0, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
